eth_header_extractor: RTL
=========================

# eth_header_extractor

Byte-stream Ethernet L2 header parser directly upstream of the metadata packager. Consumes one byte per accepted beat and extracts destination MAC, source MAC, optional 802.1Q tag, and the resolved EtherType. Publishes frame lifecycle pulses (`frame_start`, `frame_end`) and the parsed fields that the protocol classifier and metadata packager consume. Always ready; no backpressure.

## Interface
Parameters: none. Header lengths and TPIDs are package constants.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: byte beat valid; low means stall, and state holds.
- `in_data` in 8: frame byte, network order.
- `in_sof` in 1: first byte of frame; qualified by `in_valid`.
- `in_eof` in 1: last byte of frame; qualified by `in_valid`.
- `frame_start` out 1: one-cycle pulse, registered.
- `frame_end` out 1: one-cycle pulse, registered.
- `dest_mac` out 48: destination MAC.
- `src_mac` out 48: source MAC.
- `resolved_ethertype` out 16: EtherType after all tags.
- `vlan_present` out 1: at least one tag parsed.
- `vlan_id` out 12: VID of innermost parsed tag; 0 if untagged.
- `l2_header_len` out 5: 14, 18, or 22 (22 only with QinQ).
- `hdr_valid` out 1: one-cycle pulse; fields updated this cycle.
- `hdr_error` out 1: one-cycle pulse; header truncated or aborted.

## Operation
- FSM states: `IDLE`, `DMAC`, `SMAC`, `TYPE`, `TAG_TCI`, `TAG_TYPE`, `PAYLOAD`. A 3-bit byte counter indexes the bytes within a field.
- `IDLE`:
  - Non-sof beats are ignored.
  - An sof beat loads DMAC byte 0 and goes to `DMAC`.
- `DMAC`/`SMAC`: 6 bytes each; shift into shadow registers, MSB first.
- `TYPE` (2 bytes):
  - If the value is 0x8100, go to `TAG_TCI`, with `l2_header_len` of 18.
  - Otherwise latch it as the EtherType, fire `hdr_valid`, and go to `PAYLOAD`.
- `TAG_TCI` (2 bytes): VID = TCI[11:0].
- `TAG_TYPE` (2 bytes): the inner type is handled the same way as in `TYPE`, but only one tag is allowed unless QinQ is enabled.
- `PAYLOAD`: consume bytes until eof, then return to `IDLE`.
- Shadow registers copy to the output fields only on `hdr_valid`. Outputs stay stable until the next `hdr_valid`.
- EtherType values below 0x0600 (length field) are reported raw, with no special handling.
- Boundary cases:
  - eof on the final type byte: `hdr_valid` and `frame_end` fire in the same cycle; no error.
  - eof before the header is complete: `hdr_error` and `frame_end` fire; no `hdr_valid`; outputs are unchanged.
  - sof while not in `IDLE` (missing eof):
    - Abort the current frame.
    - Fire `hdr_error` only if the header was incomplete.
    - Start the new frame with this byte.
    - Pulse `frame_start`. No `frame_end` for the aborted frame.
  - sof and eof on the same beat: `frame_start`, `frame_end`, and `hdr_error` all fire; return to `IDLE`.
- Reset mid-frame: return to `IDLE` immediately. The next frame needs a fresh sof.

## Timing
- Reset values: all outputs 0; FSM in `IDLE`; counter 0.
- `frame_start` is high in the cycle after the sof beat is accepted.
- `frame_end` is high in the cycle after the eof beat is accepted.
- `hdr_valid` is high in the cycle after the final type byte is accepted. That is 15 clocks after sof with no stalls, untagged.
- Stall beats (`in_valid` low) extend latency one for one.
- All pulses are exactly one cycle wide. At most one `hdr_valid` per frame.

## Configuration
- `ETH_PARSER_QINQ_EN` defined:
  - 0x88A8 is also accepted as the outer TPID.
  - A second tag (0x8100) is parsed.
  - `l2_header_len` can be 22.
  - `vlan_id` = inner tag VID.
  - A third tag is not parsed; its TPID is reported as the EtherType.
- Undefined:
  - Only a single 0x8100 tag is parsed.
  - 0x88A8 is treated as a plain EtherType.
  - A second 0x8100 after one tag is reported as the EtherType.

## Structure
- Package `eth_parser_pkg`:
  - FSM state enum.
  - Constants `TPID_8021Q`=0x8100, `TPID_8021AD`=0x88A8, `L2_LEN_BASE`=14, `L2_TAG_LEN`=4.
  - Typedef `mac_t` (48-bit).
- No sub-module: a single FSM plus shadow shift registers, about 200 lines.

## Test plan
- Untagged frame: DA 01:02:03:04:05:06, SA 0A:0B:0C:0D:0E:0F, type 0x0800, 46-byte payload.
  - `hdr_valid` 15 clocks after sof, with those fields, `l2_header_len`=14, `vlan_present`=0.
  - `frame_end` one clock after eof.
- Tagged frame: 0x8100, TCI 0xA07B, inner 0x86DD.
  - `vlan_present`=1, `vlan_id`=0x07B, EtherType 0x86DD, len 18, `hdr_valid` at clock 19.
- Runt frame: eof on byte 9.
  - `hdr_error` and `frame_end` fire; no `hdr_valid`; previous fields unchanged.
- sof on byte 20 of an unterminated frame, then a full untagged frame.
  - No error for the first frame (its header was complete).
  - `frame_start` pulses; the second `hdr_valid` is correct.
- Random `in_valid` gaps on the tagged frame: same fields; `hdr_valid` delayed by the gap count. Also assert `rst` mid-`SMAC`: all outputs 0 immediately.
- QinQ: 0x88A8/VID 5, then 0x8100/VID 9, then 0x0800.
  - With `ETH_PARSER_QINQ_EN`: len 22, `vlan_id`=9, EtherType 0x0800.
  - Without it: EtherType 0x88A8, `vlan_present`=0.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the byte-stream Ethernet L2 header parser.
// No logic; header lengths and TPIDs live here so the parser has no parameters.
package eth_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DMAC,
        SMAC,
        TYPE,
        TAG_TCI,
        TAG_TYPE,
        PAYLOAD
    } state_t;

    typedef logic [47:0] mac_t;

    localparam logic [15:0] TPID_8021Q  = 16'h8100;
    localparam logic [15:0] TPID_8021AD = 16'h88A8;
    localparam logic [4:0]  L2_LEN_BASE = 5'd14;
    localparam logic [4:0]  L2_TAG_LEN  = 5'd4;

    function automatic logic [4:0] l2_len(input logic [1:0] tags);
        return L2_LEN_BASE + L2_TAG_LEN * {3'b000, tags};
    endfunction

endpackage

// File: rtl/eth_header_extractor.sv
// Ethernet L2 header parser: DA/SA, optional 802.1Q tag (QinQ with ETH_PARSER_QINQ_EN), resolved EtherType.
// Latency: hdr_valid one cycle after the final type byte; frame_start/frame_end one cycle after sof/eof.
// Always ready; in_valid low stalls the parser with all state held.
module eth_header_extractor
    import eth_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        frame_start,
    output logic        frame_end,
    output logic [47:0] dest_mac,
    output logic [47:0] src_mac,
    output logic [15:0] resolved_ethertype,
    output logic        vlan_present,
    output logic [11:0] vlan_id,
    output logic [4:0]  l2_header_len,
    output logic        hdr_valid,
    output logic        hdr_error
);

    state_t      state;
    logic [2:0]  byte_cnt;
    mac_t        dmac_sh;
    mac_t        smac_sh;
    logic [7:0]  hi_byte;
    logic [11:0] vid_sh;
    logic [1:0]  tag_cnt;

    logic [15:0] field16;
    logic        take_tag;
    logic        hdr_done;
    logic        hdr_open;

    assign field16  = {hi_byte, in_data};
    assign hdr_open = (state != IDLE) && (state != PAYLOAD);
    assign hdr_done = ((state == TYPE) || (state == TAG_TYPE)) && (byte_cnt == 3'd1) && !take_tag;

    // Which type values open another tag depends on how many tags are already parsed.
    always_comb begin
        take_tag = 1'b0;
`ifdef ETH_PARSER_QINQ_EN
        if (state == TYPE)
            take_tag = (field16 == TPID_8021Q) || (field16 == TPID_8021AD);
        else if ((state == TAG_TYPE) && (tag_cnt == 2'd1))
            take_tag = (field16 == TPID_8021Q);
`else
        if (state == TYPE)
            take_tag = (field16 == TPID_8021Q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            byte_cnt           <= 3'd0;
            dmac_sh            <= '0;
            smac_sh            <= '0;
            hi_byte            <= 8'd0;
            vid_sh             <= 12'd0;
            tag_cnt            <= 2'd0;
            frame_start        <= 1'b0;
            frame_end          <= 1'b0;
            dest_mac           <= '0;
            src_mac            <= '0;
            resolved_ethertype <= 16'd0;
            vlan_present       <= 1'b0;
            vlan_id            <= 12'd0;
            l2_header_len      <= 5'd0;
            hdr_valid          <= 1'b0;
            hdr_error          <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            hdr_valid   <= 1'b0;
            hdr_error   <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // A sof always restarts; the aborted frame only errors if its header was open.
                    frame_start <= 1'b1;
                    hdr_error   <= hdr_open || in_eof;
                    dmac_sh     <= {dmac_sh[39:0], in_data};
                    byte_cnt    <= 3'd1;
                    tag_cnt     <= 2'd0;
                    vid_sh      <= 12'd0;
                    if (in_eof) begin
                        frame_end <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state     <= DMAC;
                    end
                end else if (state != IDLE) begin
                    byte_cnt <= byte_cnt + 3'd1;
                    case (state)
                        DMAC: begin
                            dmac_sh <= {dmac_sh[39:0], in_data};
                            if (byte_cnt == 3'd5) begin
                                byte_cnt <= 3'd0;
                                state    <= SMAC;
                            end
                        end
                        SMAC: begin
                            smac_sh <= {smac_sh[39:0], in_data};
                            if (byte_cnt == 3'd5) begin
                                byte_cnt <= 3'd0;
                                state    <= TYPE;
                            end
                        end
                        TYPE, TAG_TYPE: begin
                            hi_byte <= in_data;
                            if (byte_cnt == 3'd1) begin
                                byte_cnt <= 3'd0;
                                if (take_tag) begin
                                    tag_cnt <= tag_cnt + 2'd1;
                                    state   <= TAG_TCI;
                                end else begin
                                    hdr_valid          <= 1'b1;
                                    dest_mac           <= dmac_sh;
                                    src_mac            <= smac_sh;
                                    resolved_ethertype <= field16;
                                    vlan_present       <= (tag_cnt != 2'd0);
                                    vlan_id            <= vid_sh;
                                    l2_header_len      <= l2_len(tag_cnt);
                                    state              <= PAYLOAD;
                                end
                            end
                        end
                        TAG_TCI: begin
                            hi_byte <= in_data;
                            if (byte_cnt == 3'd1) begin
                                byte_cnt <= 3'd0;
                                vid_sh   <= {hi_byte[3:0], in_data};
                                state    <= TAG_TYPE;
                            end
                        end
                        default: byte_cnt <= 3'd0;
                    endcase
                    if (in_eof) begin
                        frame_end <= 1'b1;
                        hdr_error <= hdr_open && !hdr_done;
                        byte_cnt  <= 3'd0;
                        state     <= IDLE;
                    end
                end
            end
        end
    end

endmodule
